// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM state codes, byte-lane
// select constants and helpers for picking or merging one byte of a
// 16-bit SRAM word.
package sram_responder_pkg;

   // FSM state codes
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Byte lane selected by cpu_address[0] (little-endian)
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   function automatic logic [7:0] lane_byte(input logic [15:0] word,
                                             input logic lane);
      return (lane == LANE_HI) ? word[15:8] : word[7:0];
   endfunction

   function automatic logic [15:0] lane_merge(input logic [15:0] word,
                                               input logic lane,
                                               input logic [7:0] data);
      logic [15:0] merged;
      merged = word;
      if (lane == LANE_HI) merged[15:8] = data;
      else                 merged[7:0]  = data;
      return merged;
   endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Bus bundle between the core's byte bus and the SRAM pins.
//  cpu_address/cpu_out/cpu_we : core request (address, write data, write)
//  cpu_in/ce                  : read data and clock-enable back to the core
//  sram_*                     : SRAM word address, data in/out, strobes, lanes
// slave  : the responder side
// master : the environment side (core + SRAM)
interface sram_responder_if #(
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] cpu_address;
   logic [7:0]        cpu_out;
   logic              cpu_we;
   logic [7:0]        cpu_in;
   logic              ce;
   logic [ADDR_W-2:0] sram_addr;
   logic [15:0]       sram_dq_o;
   logic [15:0]       sram_dq_i;
   logic              sram_dq_oe;
   logic              sram_oe;
   logic              sram_we;
   logic              sram_lb;
   logic              sram_ub;

   modport slave (
      input  cpu_address, cpu_out, cpu_we, sram_dq_i,
      output cpu_in, ce, sram_addr, sram_dq_o, sram_dq_oe,
             sram_oe, sram_we, sram_lb, sram_ub
   );

   modport master (
      output cpu_address, cpu_out, cpu_we, sram_dq_i,
      input  cpu_in, ce, sram_addr, sram_dq_o, sram_dq_oe,
             sram_oe, sram_we, sram_lb, sram_ub
   );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the core's byte bus. Serves byte reads and
// writes from a 16-bit asynchronous SRAM, keeps the last fetched word in a
// one-word read latch, and stalls the core (ce=0) while an SRAM access runs.
// Ports:
//  clock : system clock
//  reset : synchronous, active-high
//  bus   : sram_responder_if.slave (core byte bus + SRAM pins)
// Parameters:
//  WAIT   : extra SRAM access cycles (access lasts WAIT+1 clocks)
//  ADDR_W : core byte-address width
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int WAIT   = 1,
   parameter int ADDR_W = 20
) (
   input  logic             clock,
   input  logic             reset,
   sram_responder_if.slave  bus
);

   localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              valid;
   logic [ADDR_W-2:0] tag;
   logic [15:0]       latch;

   logic [ADDR_W-2:0] word_addr;
   logic              lane;
   logic              tag_match;
   logic              hit;

   // The core holds address/data stable while ce=0, so they are used
   // directly without an internal copy.
   assign word_addr = bus.cpu_address[ADDR_W-1:1];
   assign lane      = bus.cpu_address[0];
   assign tag_match = valid && (tag == word_addr);
   assign hit       = !bus.cpu_we && tag_match;

   assign bus.sram_addr = word_addr;
   assign bus.sram_dq_o = {bus.cpu_out, bus.cpu_out};
   assign bus.cpu_in    = lane_byte(latch, lane);

   always_comb begin
      bus.ce         = 1'b0;
      bus.sram_oe    = 1'b0;
      bus.sram_we    = 1'b0;
      bus.sram_dq_oe = 1'b0;
      bus.sram_lb    = 1'b0;
      bus.sram_ub    = 1'b0;
      case (state)
         ST_IDLE:  bus.ce = hit;
         ST_READ: begin
            // Whole word is fetched so both bytes land in the latch.
            bus.sram_oe = 1'b1;
            bus.sram_lb = 1'b1;
            bus.sram_ub = 1'b1;
         end
         ST_WRITE: begin
            bus.sram_we    = 1'b1;
            bus.sram_dq_oe = 1'b1;
            bus.sram_lb    = (lane == LANE_LO);
            bus.sram_ub    = (lane == LANE_HI);
         end
         ST_DONE:  bus.ce = 1'b1;
         default:  bus.ce = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         valid <= 1'b0;
         tag   <= '0;
         latch <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (bus.cpu_we)  state <= ST_WRITE;
               else if (!hit)   state <= ST_READ;
            end
            ST_READ: begin
               if (cnt == CNT_LAST) begin
                  latch <= bus.sram_dq_i;
                  tag   <= word_addr;
                  valid <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WRITE: begin
               if (cnt == CNT_LAST) begin
                  // Write-through keeps the latch coherent with the SRAM.
                  if (tag_match) latch <= lane_merge(latch, lane, bus.cpu_out);
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // One-cycle release so the core can retire the write before
            // cpu_we is looked at again.
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: an SRAM pin model, a
// transaction-level model of the responder (latch contents, stall length,
// expected strobes per cycle), directed cases and randomized traffic.
module tb_sram_responder;

   localparam int WAIT   = 1;
   localparam int ADDR_W = 20;

   logic clock;
   logic reset;

   sram_responder_if #(.ADDR_W(ADDR_W)) bus ();

   sram_responder #(.WAIT(WAIT), .ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [15:0] sram_mem [int];
   logic [15:0] ref_mem  [int];

   logic        m_valid;
   int          m_tag;
   logic [15:0] m_word;

   logic [7:0]  last_in;
   logic [31:0] last_addr;
   logic [15:0] last_dq;
   logic        last_lb, last_ub, first_ce;
   int          oe_n, we_n, celo_n;

   function automatic logic [15:0] init_word(input int a);
      logic [31:0] t;
      t = (a * 32'h9E37) ^ 32'h5A3C;
      return t[15:0];
   endfunction

   function automatic logic [15:0] sram_get(input int a);
      return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
   endfunction

   function automatic logic [15:0] ref_get(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // SRAM pin model: writes lanes when strobed, drives read data when enabled
   logic [15:0] pin_w;
   always @(negedge clock) begin
      if (bus.sram_we && bus.sram_dq_oe) begin
         pin_w = sram_get(int'(bus.sram_addr));
         if (bus.sram_lb) pin_w[7:0]  = bus.sram_dq_o[7:0];
         if (bus.sram_ub) pin_w[15:8] = bus.sram_dq_o[15:8];
         sram_mem[int'(bus.sram_addr)] = pin_w;
      end
      bus.sram_dq_i = bus.sram_oe ? sram_get(int'(bus.sram_addr)) : 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One core transaction; called at posedge+1. Checks every cycle until
   // the cycle where ce must be 1, then returns at posedge+1 of the next.
   task automatic txn(input logic [19:0] a, input logic w, input logic [7:0] d);
      int          word;
      logic        ln;
      int          stall;
      logic        is_hit;
      logic        acc;
      logic [7:0]  exp_b;
      logic [15:0] cur;
      word   = int'(a[19:1]);
      ln     = a[0];
      is_hit = !w && m_valid && (m_tag == word);
      stall  = is_hit ? 0 : WAIT + 2;
      exp_b  = 8'h00;
      if (!w) begin
         if (!is_hit) begin
            m_word  = ref_get(word);
            m_tag   = word;
            m_valid = 1'b1;
         end
         exp_b = ln ? m_word[15:8] : m_word[7:0];
      end else begin
         cur = ref_get(word);
         if (ln) cur[15:8] = d; else cur[7:0] = d;
         ref_mem[word] = cur;
         if (m_valid && m_tag == word) begin
            if (ln) m_word[15:8] = d; else m_word[7:0] = d;
         end
      end
      bus.cpu_address = a;
      bus.cpu_we      = w;
      bus.cpu_out     = d;
      oe_n = 0; we_n = 0; celo_n = 0;
      for (int k = 0; k <= stall; k++) begin
         @(negedge clock);
         acc = (k >= 1) && (k <= WAIT + 1);
         chk("ce", 32'(bus.ce), 32'(k == stall));
         chk("sram_addr", 32'(bus.sram_addr), word);
         chk("sram_oe", 32'(bus.sram_oe), 32'(acc && !w));
         chk("sram_we", 32'(bus.sram_we), 32'(acc && w));
         chk("dq_oe", 32'(bus.sram_dq_oe), 32'(acc && w));
         chk("lb", 32'(bus.sram_lb), 32'(acc && (!w || !ln)));
         chk("ub", 32'(bus.sram_ub), 32'(acc && (!w || ln)));
         if (acc && w) chk("dq_o", 32'(bus.sram_dq_o), 32'({d, d}));
         if (k == stall && !w) chk("cpu_in", 32'(bus.cpu_in), 32'(exp_b));
         if (k == 0) first_ce = bus.ce;
         if (bus.sram_oe) oe_n++;
         if (bus.sram_we) we_n++;
         if (!bus.ce) celo_n++;
         if (acc) begin
            last_dq = bus.sram_dq_o;
            last_lb = bus.sram_lb;
            last_ub = bus.sram_ub;
         end
         last_in   = bus.cpu_in;
         last_addr = 32'(bus.sram_addr);
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [19:0] ra;
      int          r;
      reset           = 1'b1;
      bus.cpu_address = '0;
      bus.cpu_we      = 1'b0;
      bus.cpu_out     = 8'h00;
      m_valid = 1'b0; m_tag = 0; m_word = 16'h0000;
      sram_mem[0]        = 16'hDDA4;  ref_mem[0]        = 16'hDDA4;
      sram_mem['h7FFF8]  = 16'h00EA;  ref_mem['h7FFF8]  = 16'h00EA;

      // reset held 3 clocks
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ce", 32'(bus.ce), 0);
      chk("rst_cpu_in", 32'(bus.cpu_in), 0);
      chk("rst_oe", 32'(bus.sram_oe), 0);
      chk("rst_we", 32'(bus.sram_we), 0);
      chk("rst_dq_oe", 32'(bus.sram_dq_oe), 0);
      chk("rst_lanes", 32'({bus.sram_lb, bus.sram_ub}), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // read miss then hit on the other lane
      txn(20'h00000, 1'b0, 8'h00);
      chk("t1_first_ce", 32'(first_ce), 0);
      chk("t2_ce_low", celo_n, 3);
      chk("t2_oe_cycles", oe_n, 2);
      chk("t2_rd_lo", 32'(last_in), 32'hA4);
      txn(20'h00001, 1'b0, 8'h00);
      chk("t2_hit_ce_low", celo_n, 0);
      chk("t2_rd_hi", 32'(last_in), 32'hDD);

      // write-through into the latched word
      txn(20'h00001, 1'b1, 8'h5A);
      chk("t3_we_cycles", we_n, 2);
      chk("t3_ce_low", celo_n, 3);
      chk("t3_lanes", 32'({last_lb, last_ub}), 32'b01);
      chk("t3_dq_o", 32'(last_dq), 32'h5A5A);
      txn(20'h00001, 1'b0, 8'h00);
      chk("t3_hit_ce_low", celo_n, 0);
      chk("t3_rd_hi", 32'(last_in), 32'h5A);
      txn(20'h00000, 1'b0, 8'h00);
      chk("t3_rd_lo", 32'(last_in), 32'hA4);

      // write elsewhere leaves latch alone
      txn(20'h00010, 1'b1, 8'h11);
      txn(20'h00000, 1'b0, 8'h00);
      chk("t4_ce_low", celo_n, 0);
      chk("t4_oe_cycles", oe_n, 0);
      chk("t4_rd", 32'(last_in), 32'hA4);

      // top of address space
      txn(20'hFFFF0, 1'b0, 8'h00);
      chk("t5_addr", last_addr, 32'h7FFF8);
      chk("t5_rd", 32'(last_in), 32'hEA);
      txn(20'hFFFF1, 1'b0, 8'h00);
      chk("t5_hit_ce_low", celo_n, 0);
      chk("t5_rd_hi", 32'(last_in), 32'h00);

      // reset in the second READ cycle aborts the fetch
      bus.cpu_address = 20'h00000;
      bus.cpu_we      = 1'b0;
      @(negedge clock);
      chk("t6_miss_ce", 32'(bus.ce), 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      chk("t6_oe_before", 32'(bus.sram_oe), 1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("t6_oe_after", 32'(bus.sram_oe), 0);
      chk("t6_ce_after", 32'(bus.ce), 0);
      chk("t6_cpu_in", 32'(bus.cpu_in), 0);
      @(posedge clock); #1;
      reset   = 1'b0;
      m_valid = 1'b0;
      txn(20'h00000, 1'b0, 8'h00);
      chk("t6_reread_ce_low", celo_n, 3);
      chk("t6_reread", 32'(last_in), 32'hA4);

      // randomized traffic over a small pool of low and top words
      for (int i = 0; i < 300; i++) begin
         r  = int'($urandom_range(0, 15));
         ra = {19'((r < 8) ? r : 32'h7FFF0 + r), 1'($urandom_range(0, 1))};
         txn(ra, 1'($urandom_range(0, 4) < 2), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
